router_switch_ctrl: RTL and testbench
=====================================

# router_switch_ctrl

Switch controller for the 5-port HeMPS mesh router. It arbitrates header requests from the five input buffers round-robin and computes the XY route from the header flit. It allocates the chosen output port and drives the crossbar selectors. It releases the output once the owning input buffer finishes sending the packet. It sits between the input buffers (h, ack_h, sender, data) and the crossbar (mux_in, mux_out, free) inside the router.

## Interface
- ADDRESS, 8'h00, router XY address: X in [7:4], Y in [3:0].
- FLIT_W, 16, flit width; the target address is flit bits [7:0].
- Port index encoding (3 bits): EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- h  in  5  per input, header flit is present at buffer head; held until ack_h.
- data  in  5×FLIT_W  per input, buffer head flit.
- sender  in  5  per input, buffer still forwarding its current packet; falls after the last flit.
- ack_h  out  5  one-cycle pulse; header of that input is routed and connected.
- free  out  5  per output, 1 = output unallocated.
- mux_out  out  5×3  per output, index of the input driving it; valid while free=0.
- mux_in  out  5×3  per input, index of the output it drives; valid while that input's connection is live.

## Operation
- FSM states: IDLE, ARB, ROUTE, GRANT.
- IDLE: if |h, go to ARB; else stay.
- ARB: pick `sel` by searching inputs from (ptr+1) mod 5 upward, wrapping; first input with h=1 wins. Go to ROUTE.
  - If h became 0 everywhere, return to IDLE.
- ROUTE: tgt = data[sel][7:0], lx/ly = ADDRESS nibbles, tx/ty = tgt nibbles. Latch `dir`:
  - tx==lx and ty==ly → LOCAL.
  - else lx<tx → EAST; lx>tx → WEST.
  - else ly<ty → NORTH; else SOUTH.
  - Compares are unsigned 4-bit. Go to GRANT.
- GRANT: if h[sel]=1 and free[dir]=1, then on the next edge:
  - free[dir]←0, mux_out[dir]←sel, mux_in[sel]←dir, ack_h[sel]←1.
  - GRANT always returns to IDLE.
- Blocked grant (free[dir]=0): no ack.
- Aborted grant (h[sel] dropped): no ack.
- ptr←sel after every GRANT visit, whether granted or not, so a blocked input cannot starve others.
- Release runs every cycle in parallel with the FSM: for each output o with free[o]=0 and sender[mux_out[o]]=0, set free[o]←1 on the next edge.
- Release and grant are mutually exclusive per output, because grant requires free=1 and release requires free=0.
- Several outputs may release in the same cycle.
- At most one grant per FSM pass; ack_h is one-hot or zero.

## Timing
- Reset values: state=IDLE, ptr=LOCAL (first search starts at EAST), free=5'b11111, ack_h=0, mux_out=0, mux_in=0.
- Header latency: h rises at edge T in IDLE → ack_h[sel] high in cycle T+4 only, with free/mux updated at the same edge.
- Back-to-back throughput: one header per 4 cycles.
- Release latency: sender falls in cycle T → free=1 in cycle T+1.
- A new grant to that output is possible from the next FSM pass.
- ack_h pulses exactly one cycle; the input must drop h no later than the cycle after ack_h.
- Reset asserted mid-operation: all connections are dropped, and all outputs return to reset values on the next edge.

## Configuration
- ROUTER_SWCTRL_BLOCK_CNT_EN defined:
  - Adds output `blocked_cnt`  out  16, a saturating count (stops at 16'hFFFF) of GRANT visits that ended with free[dir]=0.
  - Reset value 0.
- ROUTER_SWCTRL_BLOCK_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- ADDRESS=8'h11, SOUTH h=1 with data=16'h0011 → ack_h=5'b01000 exactly 4 cycles later, free[LOCAL]=0, mux_out[LOCAL]=3, mux_in[SOUTH]=4.
- ADDRESS=8'h11, LOCAL header 8'h31 → EAST. Then LOCAL header 8'h01 → WEST. Then header 8'h13 → NORTH. Then header 8'h10 → SOUTH.
- EAST, NORTH and LOCAL raise h simultaneously after reset, all to distinct outputs → grants in order EAST, NORTH, LOCAL, at 4-cycle spacing.
- WEST holds EAST output (sender=1); NORTH requests EAST output → no ack, free[EAST]=0. WEST drops sender → free[EAST]=1 next cycle, NORTH acked on a subsequent pass. With the macro defined, blocked_cnt ≥1.
- Three connections live; pulse reset low for one cycle → free=5'b11111, mux_out=0, mux_in=0, ack_h=0, FSM in IDLE.
- EAST raises h and drops it during ROUTE → no ack_h, free unchanged, FSM returns to IDLE.

Source files
------------

// File: rtl/router_switch_ctrl.sv
// Switch controller for the 5-port HeMPS mesh router: round-robin header arbitration, XY routing, crossbar allocation.
// Optional saturating blocked-grant counter is built when ROUTER_SWCTRL_BLOCK_CNT_EN is defined.
module router_switch_ctrl #(
    parameter logic [7:0] ADDRESS = 8'h00,
    parameter int         FLIT_W  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             h,
    input  logic [4:0][FLIT_W-1:0] data,
    input  logic [4:0]             sender,
    output logic [4:0]             ack_h,
    output logic [4:0]             free,
    output logic [4:0][2:0]        mux_out,
    output logic [4:0][2:0]        mux_in
`ifdef ROUTER_SWCTRL_BLOCK_CNT_EN
    ,
    output logic [15:0]            blocked_cnt
`endif
);

    localparam logic [2:0] EAST  = 3'd0;
    localparam logic [2:0] WEST  = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;

    localparam logic [3:0] LX = ADDRESS[7:4];
    localparam logic [3:0] LY = ADDRESS[3:0];

    typedef enum logic [1:0] {IDLE, ARB, ROUTE, GRANT} state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] ptr;
    logic [2:0] sel;
    logic [2:0] dir;
    logic [2:0] arb_sel;
    logic       arb_found;
    logic [3:0] cand;
    logic [2:0] route_dir;
    logic [7:0] tgt;
    logic [3:0] tx;
    logic [3:0] ty;
    logic       arb_en;
    logic       route_en;
    logic       grant_visit;
    logic       grant_fire;
    logic       unused_data;

    // Only the low byte of the header flit carries the target address
    assign unused_data = ^data;

    always_comb begin
        arb_sel   = ptr;
        arb_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= 5; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'd5) begin
                cand = cand - 4'd5;
            end
            if (!arb_found && h[cand[2:0]]) begin
                arb_found = 1'b1;
                arb_sel   = cand[2:0];
            end
        end
    end

    always_comb begin
        tgt = data[sel][7:0];
        tx  = tgt[7:4];
        ty  = tgt[3:0];
        if (tx == LX && ty == LY) begin
            route_dir = LOCAL;
        end else if (LX < tx) begin
            route_dir = EAST;
        end else if (LX > tx) begin
            route_dir = WEST;
        end else if (LY < ty) begin
            route_dir = NORTH;
        end else begin
            route_dir = SOUTH;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|h) state_next = ARB;
            ARB:     state_next = arb_found ? ROUTE : IDLE;
            ROUTE:   state_next = GRANT;
            GRANT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        arb_en      = (state == ARB) && arb_found;
        route_en    = (state == ROUTE);
        grant_visit = (state == GRANT);
        grant_fire  = grant_visit && h[sel] && free[dir];
    end

    // ptr advances on every GRANT visit so a blocked input cannot starve the others
    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr <= LOCAL;
            sel <= '0;
            dir <= '0;
        end else begin
            if (arb_en) begin
                sel <= arb_sel;
            end
            if (route_en) begin
                dir <= route_dir;
            end
            if (grant_visit) begin
                ptr <= sel;
            end
        end
    end

    // Release never targets an output that is being granted, since they require opposite free values
    always_ff @(posedge clock) begin
        if (!reset) begin
            free    <= '1;
            ack_h   <= '0;
            mux_out <= '0;
            mux_in  <= '0;
        end else begin
            ack_h <= '0;
            for (int o = 0; o < 5; o++) begin
                if (!free[o] && !sender[mux_out[o]]) begin
                    free[o] <= 1'b1;
                end
            end
            if (grant_fire) begin
                free[dir]    <= 1'b0;
                mux_out[dir] <= sel;
                mux_in[sel]  <= dir;
                ack_h[sel]   <= 1'b1;
            end
        end
    end

`ifdef ROUTER_SWCTRL_BLOCK_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            blocked_cnt <= '0;
        end else if (grant_visit && !free[dir] && blocked_cnt != 16'hFFFF) begin
            blocked_cnt <= blocked_cnt + 16'd1;
        end
    end
`else
    // Blocked-grant statistics are not built in this configuration
`endif

endmodule

// File: tb/tb_router_switch_ctrl.sv
// Directed testbench for router_switch_ctrl at ADDRESS=8'h11.
module tb_router_switch_ctrl;

    logic              clock;
    logic              reset;
    logic [4:0]        h;
    logic [4:0][15:0]  data;
    logic [4:0]        sender;
    logic [4:0]        ack_h;
    logic [4:0]        free;
    logic [4:0][2:0]   mux_out;
    logic [4:0][2:0]   mux_in;
`ifdef ROUTER_SWCTRL_BLOCK_CNT_EN
    logic [15:0]       blocked_cnt;
`endif

    int vectors;
    int miscompares;

    router_switch_ctrl #(.ADDRESS(8'h11), .FLIT_W(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .h       (h),
        .data    (data),
        .sender  (sender),
        .ack_h   (ack_h),
        .free    (free),
        .mux_out (mux_out),
        .mux_in  (mux_in)
`ifdef ROUTER_SWCTRL_BLOCK_CNT_EN
        ,
        .blocked_cnt (blocked_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset  = 1'b0;
        h      = '0;
        sender = '0;
        data   = '0;
        tick();
        reset = 1'b1;
    endtask

    // Waits a bounded number of cycles for ack_h[src]; lat stays 0 on timeout
    task automatic wait_ack(input int src, input int budget, output int lat);
        logic done;
        done = 1'b0;
        lat  = 0;
        for (int t = 1; t <= budget; t++) begin
            if (!done) begin
                tick();
                if (ack_h[src]) begin
                    lat  = t;
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic do_grant(input int src, input logic [7:0] tgt, output int lat, output logic [4:0] ack_seen);
        data[src]   = {8'h00, tgt};
        h[src]      = 1'b1;
        sender[src] = 1'b1;
        wait_ack(src, 8, lat);
        ack_seen = ack_h;
        h[src]   = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        h      = '0;
        sender = '0;
        data   = '0;
        tick();
        tick();
        vectors++;
        if (free !== 5'b11111) begin miscompares++; $display("[TB] FAIL reset_free: got %b expected 11111", free); end
        vectors++;
        if (ack_h !== 5'b00000) begin miscompares++; $display("[TB] FAIL reset_ack: got %b expected 00000", ack_h); end
        vectors++;
        if (mux_out !== 15'd0) begin miscompares++; $display("[TB] FAIL reset_mux_out: got %h expected 0", mux_out); end
        vectors++;
        if (mux_in !== 15'd0) begin miscompares++; $display("[TB] FAIL reset_mux_in: got %h expected 0", mux_in); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_south_to_local();
        logic [4:0] exp;
        data[3]   = 16'h0011;
        h[3]      = 1'b1;
        sender[3] = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            exp = (t == 4) ? 5'b01000 : 5'b00000;
            vectors++;
            if (ack_h !== exp) begin miscompares++; $display("[TB] FAIL south_ack t%0d: got %b expected %b", t, ack_h, exp); end
        end
        h[3] = 1'b0;
        vectors++;
        if (free !== 5'b01111) begin miscompares++; $display("[TB] FAIL south_free: got %b expected 01111", free); end
        vectors++;
        if (mux_out[4] !== 3'd3) begin miscompares++; $display("[TB] FAIL south_mux_out: got %0d expected 3", mux_out[4]); end
        vectors++;
        if (mux_in[3] !== 3'd4) begin miscompares++; $display("[TB] FAIL south_mux_in: got %0d expected 4", mux_in[3]); end
        tick();
        vectors++;
        if (ack_h !== 5'b00000) begin miscompares++; $display("[TB] FAIL south_ack_pulse: got %b expected 00000", ack_h); end
        vectors++;
        if (free !== 5'b01111) begin miscompares++; $display("[TB] FAIL south_hold: got %b expected 01111", free); end
        sender[3] = 1'b0;
        tick();
        vectors++;
        if (free !== 5'b11111) begin miscompares++; $display("[TB] FAIL south_release: got %b expected 11111", free); end
    endtask

    task automatic test_route_dirs();
        logic [7:0] tgts [4];
        logic [2:0] dirs [4];
        logic [4:0] ackv;
        logic [4:0] ef;
        int         lat;
        tgts = '{8'h31, 8'h01, 8'h13, 8'h10};
        dirs = '{3'd0, 3'd1, 3'd2, 3'd3};
        for (int i = 0; i < 4; i++) begin
            do_grant(4, tgts[i], lat, ackv);
            ef = 5'b11111;
            ef[dirs[i]] = 1'b0;
            vectors++;
            if (lat !== 4) begin miscompares++; $display("[TB] FAIL route%0d_latency: got %0d expected 4", i, lat); end
            vectors++;
            if (ackv !== 5'b10000) begin miscompares++; $display("[TB] FAIL route%0d_ack: got %b expected 10000", i, ackv); end
            vectors++;
            if (mux_in[4] !== dirs[i]) begin miscompares++; $display("[TB] FAIL route%0d_mux_in: got %0d expected %0d", i, mux_in[4], dirs[i]); end
            vectors++;
            if (mux_out[dirs[i]] !== 3'd4) begin miscompares++; $display("[TB] FAIL route%0d_mux_out: got %0d expected 4", i, mux_out[dirs[i]]); end
            vectors++;
            if (free !== ef) begin miscompares++; $display("[TB] FAIL route%0d_free: got %b expected %b", i, free, ef); end
            sender[4] = 1'b0;
            tick();
            vectors++;
            if (free !== 5'b11111) begin miscompares++; $display("[TB] FAIL route%0d_release: got %b expected 11111", i, free); end
        end
    endtask

    task automatic test_simultaneous();
        int         order [3];
        logic [4:0] exp;
        order = '{0, 2, 4};
        apply_reset();
        data[0] = 16'h0031;
        data[2] = 16'h0001;
        data[4] = 16'h0013;
        h       = 5'b10101;
        sender  = 5'b10101;
        for (int g = 0; g < 3; g++) begin
            for (int t = 1; t <= 4; t++) begin
                tick();
                exp = (t == 4) ? (5'b00001 << order[g]) : 5'b00000;
                vectors++;
                if (ack_h !== exp) begin miscompares++; $display("[TB] FAIL sim_ack g%0d t%0d: got %b expected %b", g, t, ack_h, exp); end
            end
            h[order[g]] = 1'b0;
        end
        vectors++;
        if (free !== 5'b11000) begin miscompares++; $display("[TB] FAIL sim_free: got %b expected 11000", free); end
        vectors++;
        if (mux_out[1] !== 3'd2) begin miscompares++; $display("[TB] FAIL sim_mux_out_west: got %0d expected 2", mux_out[1]); end
        vectors++;
        if (mux_out[2] !== 3'd4) begin miscompares++; $display("[TB] FAIL sim_mux_out_north: got %0d expected 4", mux_out[2]); end
        sender = '0;
        tick();
        vectors++;
        if (free !== 5'b11111) begin miscompares++; $display("[TB] FAIL sim_release: got %b expected 11111", free); end
    endtask

    task automatic test_blocked();
        logic [4:0] ackv;
        int         lat;
        apply_reset();
        do_grant(1, 8'h31, lat, ackv);
        vectors++;
        if (ackv !== 5'b00010) begin miscompares++; $display("[TB] FAIL blk_first_ack: got %b expected 00010", ackv); end
        tick();
        data[2]   = 16'h0031;
        h[2]      = 1'b1;
        sender[2] = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            vectors++;
            if (ack_h !== 5'b00000) begin miscompares++; $display("[TB] FAIL blk_ack t%0d: got %b expected 00000", t, ack_h); end
            vectors++;
            if (free !== 5'b11110) begin miscompares++; $display("[TB] FAIL blk_free t%0d: got %b expected 11110", t, free); end
        end
        sender[1] = 1'b0;
        tick();
        vectors++;
        if (free !== 5'b11111) begin miscompares++; $display("[TB] FAIL blk_release: got %b expected 11111", free); end
        wait_ack(2, 10, lat);
        h[2] = 1'b0;
        vectors++;
        if (lat !== 3) begin miscompares++; $display("[TB] FAIL blk_retry_latency: got %0d expected 3", lat); end
        vectors++;
        if (free !== 5'b11110) begin miscompares++; $display("[TB] FAIL blk_regrant_free: got %b expected 11110", free); end
        vectors++;
        if (mux_out[0] !== 3'd2) begin miscompares++; $display("[TB] FAIL blk_mux_out: got %0d expected 2", mux_out[0]); end
        vectors++;
        if (mux_in[2] !== 3'd0) begin miscompares++; $display("[TB] FAIL blk_mux_in: got %0d expected 0", mux_in[2]); end
`ifdef ROUTER_SWCTRL_BLOCK_CNT_EN
        vectors++;
        if (blocked_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL blk_count: got %0d expected 2", blocked_cnt); end
`endif
        sender = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [4:0] ackv;
        int         lat;
        apply_reset();
        do_grant(3, 8'h10, lat, ackv);
        vectors++;
        if (ackv !== 5'b01000) begin miscompares++; $display("[TB] FAIL mid_ack0: got %b expected 01000", ackv); end
        do_grant(4, 8'h13, lat, ackv);
        vectors++;
        if (ackv !== 5'b10000) begin miscompares++; $display("[TB] FAIL mid_ack1: got %b expected 10000", ackv); end
        do_grant(1, 8'h01, lat, ackv);
        vectors++;
        if (ackv !== 5'b00010) begin miscompares++; $display("[TB] FAIL mid_ack2: got %b expected 00010", ackv); end
        vectors++;
        if (free !== 5'b10001) begin miscompares++; $display("[TB] FAIL mid_free_live: got %b expected 10001", free); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        vectors++;
        if (free !== 5'b11111) begin miscompares++; $display("[TB] FAIL mid_free: got %b expected 11111", free); end
        vectors++;
        if (ack_h !== 5'b00000) begin miscompares++; $display("[TB] FAIL mid_ack: got %b expected 00000", ack_h); end
        vectors++;
        if (mux_out !== 15'd0) begin miscompares++; $display("[TB] FAIL mid_mux_out: got %h expected 0", mux_out); end
        vectors++;
        if (mux_in !== 15'd0) begin miscompares++; $display("[TB] FAIL mid_mux_in: got %h expected 0", mux_in); end
        // Pointer is back at LOCAL, so EAST must win over NORTH
        sender  = 5'b00101;
        data[0] = 16'h0031;
        data[2] = 16'h0001;
        h       = 5'b00101;
        wait_ack(0, 8, lat);
        vectors++;
        if (lat !== 4) begin miscompares++; $display("[TB] FAIL mid_east_latency: got %0d expected 4", lat); end
        vectors++;
        if (ack_h !== 5'b00001) begin miscompares++; $display("[TB] FAIL mid_east_ack: got %b expected 00001", ack_h); end
        h[0] = 1'b0;
        wait_ack(2, 8, lat);
        h[2] = 1'b0;
        vectors++;
        if (lat !== 4) begin miscompares++; $display("[TB] FAIL mid_north_latency: got %0d expected 4", lat); end
        sender = '0;
        tick();
    endtask

    task automatic test_abort();
        logic [4:0] ackv;
        int         lat;
        apply_reset();
        data[0]   = 16'h0031;
        h[0]      = 1'b1;
        sender[0] = 1'b1;
        tick();
        tick();
        h[0] = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            vectors++;
            if (ack_h !== 5'b00000) begin miscompares++; $display("[TB] FAIL abort_ack t%0d: got %b expected 00000", t, ack_h); end
            vectors++;
            if (free !== 5'b11111) begin miscompares++; $display("[TB] FAIL abort_free t%0d: got %b expected 11111", t, free); end
        end
        sender[0] = 1'b0;
        do_grant(4, 8'h13, lat, ackv);
        vectors++;
        if (lat !== 4) begin miscompares++; $display("[TB] FAIL abort_idle_latency: got %0d expected 4", lat); end
        vectors++;
        if (ackv !== 5'b10000) begin miscompares++; $display("[TB] FAIL abort_next_ack: got %b expected 10000", ackv); end
        sender = '0;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        h           = '0;
        sender      = '0;
        data        = '0;
        test_reset();
        test_south_to_local();
        test_route_dirs();
        test_simultaneous();
        test_blocked();
        test_reset_mid();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
